// File: rtl/inst_loader_if.sv
// inst_loader_if: bundles the boot byte stream, instruction-memory write port and load status.
// Latency: none; this is the signal bundle only.
// Backpressure: the byte stream is valid/ready; the memory write port cannot stall the loader.
//
// Modports:
//   master - loader side: consumes start/num_words/byte stream, drives byte_ready,
//            the memory write port and the status outputs.
//   slave  - boot source / host side: the mirror image of master.
//
// Signals:
//   start, num_words           load request and word count (num_words is 0..2**ADDR_W)
//   byte_valid, byte_data      incoming byte stream
//   byte_ready                 loader can take a byte this cycle
//   mem_we, mem_addr, mem_wdata  one-cycle word write into instruction memory
//   busy, cpu_hold, done       load in progress, CPU stall, completion pulse
//   chk_err                    checksum mismatch of the last load (0 when checksum build is off)
interface inst_loader_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W:0]   num_words;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic              busy;
   logic              cpu_hold;
   logic              done;
   logic              chk_err;

   modport master (
      input  start, num_words, byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, chk_err
   );

   modport slave (
      output start, num_words, byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, chk_err
   );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: a word is written the cycle after its 4th byte is accepted; at least 5 cycles per word.
// Backpressure: byte_ready is decoded from state (high in RECV/CHK only); input gaps stall indefinitely.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; abandons any load in progress
//   bus       inst_loader_if.master: start/num_words, byte stream, memory write port,
//             busy/cpu_hold/done status and chk_err
//
// Parameters:
//   ADDR_W    word-index width; memory depth is 2**ADDR_W words, byte address = {index, 2'b00}
//   BASE_IDX  word index of the first word written; the index wraps modulo 2**ADDR_W
//
// Build option:
//   INST_LOADER_CHKSUM_EN  when defined, one checksum byte (XOR of all payload bytes) follows
//                          the last word; a mismatch sets chk_err until the next accepted start.
//                          When undefined there is no CHK state and chk_err is tied low.
module inst_loader #(
   parameter int ADDR_W   = 8,
   parameter int BASE_IDX = 0
) (
   input  logic          clk,
   input  logic          rst,
   inst_loader_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      CHK   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_IDX);

   state_t            state;
   state_t            nstate;

   logic [ADDR_W:0]   nwords;     // word count latched at the accepted start
   logic [ADDR_W:0]   word_idx;   // index of the word being assembled, 0-based
   logic [1:0]        byte_cnt;   // byte position inside the current word
   logic [23:0]       shreg;      // first three bytes of the current word, oldest in [23:16]
   logic [ADDR_W-1:0] idx_wrap;   // memory word index, wrapping at the memory depth
   logic              xfer;
   logic              last_word;

   // ------------------------------------------------------------------
   // Decoded outputs: everything visible to the CPU side comes from the
   // state register, so there is no input-to-byte_ready path.
   // ------------------------------------------------------------------
   assign bus.byte_ready = (state == RECV) || (state == CHK);
   assign bus.mem_we     = (state == WRITE);
   assign bus.busy       = (state != IDLE);
   assign bus.cpu_hold   = (state != IDLE);
   assign bus.done       = (state == DONE);

   assign xfer      = bus.byte_valid & bus.byte_ready;
   // nwords is never zero outside IDLE/DONE, so the subtraction cannot underflow where it matters.
   assign last_word = (word_idx == nwords - ONE);
   // Adding in ADDR_W bits gives the modulo-depth wrap for free.
   assign idx_wrap  = BASE + word_idx[ADDR_W-1:0];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      nstate = state;
      case (state)
         IDLE: begin
            // A zero-length load completes immediately without touching memory.
            if (bus.start) begin
               nstate = (bus.num_words != '0) ? RECV : DONE;
            end
         end
         RECV: begin
            if (xfer && (byte_cnt == 2'd3)) begin
               nstate = WRITE;
            end
         end
         WRITE: begin
            if (last_word) begin
`ifdef INST_LOADER_CHKSUM_EN
               nstate = CHK;
`else
               nstate = DONE;
`endif
            end else begin
               nstate = RECV;
            end
         end
         CHK: begin
            if (xfer) begin
               nstate = DONE;
            end
         end
         DONE: begin
            nstate = IDLE;
         end
         default: begin
            nstate = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: word assembly, write address/data and word counter.
   // mem_addr/mem_wdata are captured on the 4th byte so they are stable
   // for the whole WRITE cycle and hold their value afterwards.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nwords        <= '0;
         word_idx      <= '0;
         byte_cnt      <= '0;
         shreg         <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  nwords   <= bus.num_words;
                  word_idx <= '0;
                  byte_cnt <= '0;
               end
            end
            RECV: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     bus.mem_wdata <= {shreg, bus.byte_data};
                     bus.mem_addr  <= {{(30-ADDR_W){1'b0}}, idx_wrap, 2'b00};
                  end else begin
                     shreg <= {shreg[15:0], bus.byte_data};
                  end
               end
            end
            WRITE: begin
               if (!last_word) begin
                  word_idx <= word_idx + ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Optional trailing checksum byte
   // ------------------------------------------------------------------
`ifdef INST_LOADER_CHKSUM_EN
   logic [7:0] chk_acc;   // running XOR of payload bytes of the current load
   logic       chk_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_acc   <= '0;
         chk_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  chk_acc   <= '0;
                  chk_err_q <= 1'b0;
               end
            end
            RECV: begin
               if (xfer) begin
                  chk_acc <= chk_acc ^ bus.byte_data;
               end
            end
            CHK: begin
               if (xfer) begin
                  chk_err_q <= (bus.byte_data != chk_acc);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.chk_err = chk_err_q;
`else
   assign bus.chk_err = 1'b0;
`endif

endmodule
